// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath: mover FSM state encodings and
// small elaboration-time helpers.
package tpu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_READ  = 3'd1;
    localparam state_t S_DRAIN = 3'd2;
    localparam state_t S_WRITE = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Width of a lane index; never below one bit so LANES=1 still elaborates.
    function automatic int unsigned lane_idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: acc <= acc + a*b on valid, cleared by clr.
// The accumulator wraps modulo 2^ACC_WIDTH.
module mac_lane #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int SIGNED        = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     valid,
    input  logic [IN_DATA_WIDTH-1:0] a,
    input  logic [IN_DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]     acc
);

    localparam int PW = 2 * IN_DATA_WIDTH;

    logic                 sx_a;
    logic                 sx_b;
    logic [PW-1:0]        a_x;
    logic [PW-1:0]        b_x;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_x;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_q;

    // Operands are widened to the product width first, so the low PW bits of
    // one unsigned multiply are correct for both signed and unsigned lanes.
    assign sx_a = (SIGNED != 0) && a[IN_DATA_WIDTH-1];
    assign sx_b = (SIGNED != 0) && b[IN_DATA_WIDTH-1];
    assign a_x  = {{IN_DATA_WIDTH{sx_a}}, a};
    assign b_x  = {{IN_DATA_WIDTH{sx_b}}, b};
    assign prod = a_x * b_x;

    if (ACC_WIDTH > PW) begin : g_ext
        assign prod_x = {{(ACC_WIDTH - PW){(SIGNED != 0) && prod[PW-1]}}, prod};
    end else begin : g_trunc
        assign prod_x = prod[ACC_WIDTH-1:0];
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (valid) begin
            acc_d = acc_q + prod_x;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/bram_mac_mover.sv
// Streams word pairs from BRAM0/BRAM1 through LANES MAC lanes and writes the
// lane accumulators back to BRAM2.
module bram_mac_mover
    import tpu_pkg::*;
#(
    parameter  int LANES         = 4,
    parameter  int IN_DATA_WIDTH = 8,
    parameter  int ACC_WIDTH     = 32,
    parameter  int AWIDTH        = 12,
    parameter  int CNT_BIT       = 31,
    parameter  int SIGNED        = 0,
    localparam int DWIDTH        = LANES * IN_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_run_i,
    input  logic [CNT_BIT-1:0]   run_count_i,
    input  logic                 acc_clear_i,
    input  logic [AWIDTH-1:0]    rd_base_i,
    input  logic [AWIDTH-1:0]    wr_base_i,
    output logic                 idle_o,
    output logic                 read_o,
    output logic                 write_o,
    output logic                 done_o,
    output logic [AWIDTH-1:0]    addr_b0_o,
    output logic                 ce_b0_o,
    output logic                 we_b0_o,
    input  logic [DWIDTH-1:0]    q_b0_i,
    output logic [AWIDTH-1:0]    addr_b1_o,
    output logic                 ce_b1_o,
    output logic                 we_b1_o,
    input  logic [DWIDTH-1:0]    q_b1_i,
    output logic [AWIDTH-1:0]    addr_b2_o,
    output logic                 ce_b2_o,
    output logic                 we_b2_o,
    output logic [ACC_WIDTH-1:0] d_b2_o
);

    localparam int LW = lane_idx_width(LANES);

    state_t               state_q;
    state_t               state_d;
    logic [AWIDTH-1:0]    rd_addr_q;
    logic [AWIDTH-1:0]    rd_addr_d;
    logic [AWIDTH-1:0]    wr_addr_q;
    logic [AWIDTH-1:0]    wr_addr_d;
    logic [CNT_BIT-1:0]   rd_left_q;
    logic [CNT_BIT-1:0]   rd_left_d;
    logic [LW-1:0]        wr_idx_q;
    logic [LW-1:0]        wr_idx_d;
    logic                 rd_valid_q;
    logic                 rd_valid_d;
    logic                 acc_clr;
    logic [ACC_WIDTH-1:0] acc_vec [LANES];

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        rd_left_d  = rd_left_q;
        wr_idx_d   = wr_idx_q;
        acc_clr    = 1'b0;
        // BRAM read data lags the address by one cycle, so valid is READ delayed.
        rd_valid_d = (state_q == S_READ);
        case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    rd_addr_d = rd_base_i;
                    wr_addr_d = wr_base_i;
                    rd_left_d = run_count_i;
                    wr_idx_d  = '0;
                    if (run_count_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        acc_clr = acc_clear_i;
                    end
                end
            end
            S_READ: begin
                rd_addr_d = rd_addr_q + AWIDTH'(1);
                rd_left_d = rd_left_q - CNT_BIT'(1);
                if (rd_left_q == CNT_BIT'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_addr_d = wr_addr_q + AWIDTH'(1);
                wr_idx_d  = wr_idx_q + LW'(1);
                if (wr_idx_q == LW'(LANES - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_left_q  <= '0;
            wr_idx_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_left_q  <= rd_left_d;
            wr_idx_q   <= wr_idx_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Lane 0 takes the most significant operand slice.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH),
            .SIGNED       (SIGNED)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (acc_clr),
            .valid  (rd_valid_q),
            .a      (q_b0_i[(LANES - k) * IN_DATA_WIDTH - 1 -: IN_DATA_WIDTH]),
            .b      (q_b1_i[(LANES - k) * IN_DATA_WIDTH - 1 -: IN_DATA_WIDTH]),
            .acc    (acc_vec[k])
        );
    end

    assign idle_o    = (state_q == S_IDLE);
    assign read_o    = (state_q == S_READ);
    assign write_o   = (state_q == S_WRITE);
    assign done_o    = (state_q == S_DONE);

    assign addr_b0_o = read_o ? rd_addr_q : '0;
    assign addr_b1_o = read_o ? rd_addr_q : '0;
    assign ce_b0_o   = read_o;
    assign ce_b1_o   = read_o;
    assign we_b0_o   = 1'b0;
    assign we_b1_o   = 1'b0;

    // Write-side outputs are decoded from state so reset drops them at once.
    assign addr_b2_o = write_o ? wr_addr_q : '0;
    assign ce_b2_o   = write_o;
    assign we_b2_o   = write_o;
    assign d_b2_o    = write_o ? acc_vec[wr_idx_q] : '0;

endmodule

// File: doc/bram_mac_mover.md
# bram_mac_mover

Parametrised successor of the 4-core BRAM data mover. It streams `run_count_i` word pairs from BRAM0 (inputs) and BRAM1 (weights), splits each word into `LANES` operands, and multiply-accumulates each lane. It then writes the `LANES` accumulators back to a third BRAM (BRAM2). It sits between the register block and the three BRAMs and is the compute core of the TPU datapath.

## Interface
- LANES, 4, number of MAC lanes
- IN_DATA_WIDTH, 8, operand width per lane
- ACC_WIDTH, 32, accumulator and BRAM2 word width
- AWIDTH, 12, BRAM address width
- CNT_BIT, 31, run-count width
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
- DWIDTH (localparam) = LANES*IN_DATA_WIDTH, BRAM0/BRAM1 word width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start_run_i  in  1  start pulse; sampled only in IDLE
- run_count_i  in  CNT_BIT  number of word pairs to read; sampled with start
- acc_clear_i  in  1  sampled with start; 1 zeroes accumulators, 0 keeps accumulating
- rd_base_i  in  AWIDTH  BRAM0/BRAM1 start address; sampled with start
- wr_base_i  in  AWIDTH  BRAM2 start address; sampled with start
- idle_o / read_o / write_o / done_o  out  1  state flags
- addr_b0_o, addr_b1_o  out  AWIDTH  read addresses
- ce_b0_o, ce_b1_o  out  1  chip enables
- we_b0_o, we_b1_o  out  1  tied 0
- q_b0_i, q_b1_i  in  DWIDTH  read data, one cycle after address
- addr_b2_o  out  AWIDTH  write address
- ce_b2_o, we_b2_o  out  1  write strobes
- d_b2_o  out  ACC_WIDTH  write data

## Operation
- **States:**
  - IDLE →(start_run_i, count≠0) READ
  - IDLE →(start_run_i, count=0) DONE, with no memory access and accumulators untouched
  - READ →(last address issued) DRAIN
  - DRAIN → WRITE (always 1 cycle)
  - WRITE →(lane LANES-1 written) DONE
  - DONE → IDLE
- **State flags:** idle_o = IDLE; read_o = READ; write_o = WRITE; done_o = DONE. DRAIN drives all four low.
- **Start in IDLE:** at the sampling edge, register the count and base addresses. If acc_clear_i=1, zero every accumulator.
- **Start outside IDLE:** ignored; run_count_i, rd_base_i, wr_base_i and acc_clear_i are don't-care.
- **READ, cycle i (0..N-1):**
  - addr_b0_o = addr_b1_o = rd_base + i, mod 2^AWIDTH (wraps silently).
  - ce_b0_o = ce_b1_o = 1.
- **Data valid:** a delayed read flag (read_o registered once) marks q_b*_i valid.
- **Lane k:**
  - Operands are bits [(LANES-k)*IN_DATA_WIDTH-1 : (LANES-1-k)*IN_DATA_WIDTH] of q_b0_i and q_b1_i. Lane 0 is the MSB slice.
  - On a valid cycle: acc_k <= acc_k + a_k*b_k.
  - Product is 2*IN_DATA_WIDTH wide, extended to ACC_WIDTH (sign-extended iff SIGNED=1).
  - Sum wraps mod 2^ACC_WIDTH; there is no saturation.
- **WRITE, cycle k (0..LANES-1):**
  - addr_b2_o = wr_base + k, mod 2^AWIDTH.
  - ce_b2_o = we_b2_o = 1.
  - d_b2_o = acc_k.
- **Accumulators** hold their value after WRITE, so the next run with acc_clear_i=0 continues from them.

## Timing
- **Reset values:**
  - Every output is 0 except idle_o = 1.
  - Accumulators, counters and the delayed read flag are 0.
  - State is IDLE.
- **Reset mid-run** forces all of the above immediately. No write strobe is asserted after reset_n falls.
- **Latency:** with the start sampled at edge 0 and N≥1, done_o is high for exactly one cycle following edge N+LANES+1.
- **Read/write overlap:** none. ce_b0_o/ce_b1_o and ce_b2_o are never high in the same cycle.
- **DRAIN** exists so the last read word (valid in the cycle after the final READ cycle) is accumulated before WRITE samples acc_0.
- **Restart:** start_run_i held high is taken again in the first IDLE cycle after DONE.

## Structure
- **Shared package (tpu_pkg):** state encodings S_IDLE/S_READ/S_DRAIN/S_WRITE/S_DONE.
- **Sub-module mac_lane:** parameters IN_DATA_WIDTH, ACC_WIDTH, SIGNED; ports clk, reset_n, clr, valid, a, b, acc.
  - Instantiated LANES times with a generate loop.
  - clr has priority over valid in the same cycle.
- **Top level** holds the FSM, read/write counters and BRAM muxing.

## Test plan
- **Unsigned run:** LANES=4, N=4, acc_clear=1, every BRAM0 word 0x01020304, every BRAM1 word 0x02020202. Expect BRAM2[wr_base..+3] = 8, 16, 24, 32 and done_o after edge 9.
- **Signed wrap:** SIGNED=1, one word pair, lane 0 operands 0x80 × 0x7F. Expect acc_0 = 0xFFFFC080. Repeat with SIGNED=0: expect 0x00003F80.
- **Chained runs:** run 1 with clear=1, then run 2 with clear=0 on the same data. Expect BRAM2 values doubled. A third run with clear=1 restores the original values.
- **Boundaries:**
  - run_count=0: no ce/we pulses, done_o on the cycle after start.
  - rd_base=0xFFE with N=4: read addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Ignored start:** start pulsed during READ and WRITE. Expect no effect on count, addresses or results.
- **Reset mid-run:** reset_n asserted during WRITE at k=2. Expect idle_o=1, we_b2_o=0 immediately, and only BRAM2[wr_base..+1] modified.
